// File: rtl/dmi_arbiter.sv
// Two-master DMI arbiter: round-robin grant, one outstanding access, response routed
// back to its owner, with a watchdog that turns a hung DM access into a failed response.
module dmi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req_valid,
  output logic        o_m0_req_ready,
  input  logic [6:0]  i_m0_req_address,
  input  logic [31:0] i_m0_req_data,
  input  logic [1:0]  i_m0_req_op,
  output logic        o_m0_rsp_valid,
  input  logic        i_m0_rsp_ready,
  output logic [31:0] o_m0_rsp_data,
  output logic [1:0]  o_m0_rsp_op,
  input  logic        i_m1_req_valid,
  output logic        o_m1_req_ready,
  input  logic [6:0]  i_m1_req_address,
  input  logic [31:0] i_m1_req_data,
  input  logic [1:0]  i_m1_req_op,
  output logic        o_m1_rsp_valid,
  input  logic        i_m1_rsp_ready,
  output logic [31:0] o_m1_rsp_data,
  output logic [1:0]  o_m1_rsp_op,
  output logic        o_dm_req_valid,
  input  logic        i_dm_req_ready,
  output logic [6:0]  o_dm_req_address,
  output logic [31:0] o_dm_req_data,
  output logic [1:0]  o_dm_req_op,
  input  logic        i_dm_rsp_valid,
  output logic        o_dm_rsp_ready,
  input  logic [31:0] i_dm_rsp_data,
  input  logic [1:0]  i_dm_rsp_op,
  output logic        o_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RSP} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [6:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rop_q, rop_d;
  logic             stale_q, stale_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             gnt0_s, gnt1_s, own_rsp_ready_s;

  // Pointer only breaks ties; a lone requester always wins.
  assign gnt0_s = i_m0_req_valid && (!i_m1_req_valid || !ptr_q);
  assign gnt1_s = i_m1_req_valid && (!i_m0_req_valid ||  ptr_q);
  assign own_rsp_ready_s = owner_q ? i_m1_rsp_ready : i_m0_rsp_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      addr_q    <= 7'd0;
      wdata_q   <= 32'd0;
      op_q      <= 2'd0;
      rdata_q   <= 32'd0;
      rop_q     <= 2'd0;
      stale_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      rdata_q   <= rdata_d;
      rop_q     <= rop_d;
      stale_q   <= stale_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    op_d           = op_q;
    rdata_d        = rdata_q;
    rop_d          = rop_q;
    stale_d        = stale_q;
    cnt_d          = cnt_q;
    timeout_d      = 1'b0;
    o_m0_req_ready = 1'b0;
    o_m1_req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_m0_req_ready = gnt0_s;
        o_m1_req_ready = gnt1_s;
        if (gnt0_s || gnt1_s) begin
          owner_d = gnt1_s;
          addr_d  = gnt1_s ? i_m1_req_address : i_m0_req_address;
          wdata_d = gnt1_s ? i_m1_req_data    : i_m0_req_data;
          op_d    = gnt1_s ? i_m1_req_op      : i_m0_req_op;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_dm_req_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (i_dm_rsp_valid) begin
          if (stale_q) begin
            // Late answer to an access that already timed out.
            stale_d = 1'b0;
          end else begin
            rdata_d = i_dm_rsp_data;
            rop_d   = i_dm_rsp_op;
            state_d = ST_RSP;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          rdata_d   = 32'd0;
          rop_d     = 2'b10;
          stale_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RSP: begin
        if (own_rsp_ready_s) begin
          ptr_d   = ~owner_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_dm_req_valid   = (state_q == ST_REQ);
  assign o_dm_req_address = addr_q;
  assign o_dm_req_data    = wdata_q;
  assign o_dm_req_op      = op_q;
  assign o_dm_rsp_ready   = (state_q != ST_RSP);
  assign o_m0_rsp_valid   = (state_q == ST_RSP) && !owner_q;
  assign o_m1_rsp_valid   = (state_q == ST_RSP) &&  owner_q;
  assign o_m0_rsp_data    = rdata_q;
  assign o_m0_rsp_op      = rop_q;
  assign o_m1_rsp_data    = rdata_q;
  assign o_m1_rsp_op      = rop_q;
  assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed plus randomized bench for dmi_arbiter; a transaction-level model tracks the
// round-robin pointer and the stale-response flag to predict owner and response.
module tb_dmi_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset = 1'b0;
  logic        i_m0_req_valid = 1'b0, i_m1_req_valid = 1'b0;
  logic        o_m0_req_ready, o_m1_req_ready;
  logic [6:0]  i_m0_req_address = 7'd0, i_m1_req_address = 7'd0;
  logic [31:0] i_m0_req_data = 32'd0, i_m1_req_data = 32'd0;
  logic [1:0]  i_m0_req_op = 2'd0, i_m1_req_op = 2'd0;
  logic        o_m0_rsp_valid, o_m1_rsp_valid;
  logic        i_m0_rsp_ready = 1'b0, i_m1_rsp_ready = 1'b0;
  logic [31:0] o_m0_rsp_data, o_m1_rsp_data;
  logic [1:0]  o_m0_rsp_op, o_m1_rsp_op;
  logic        o_dm_req_valid, i_dm_req_ready = 1'b0;
  logic [6:0]  o_dm_req_address;
  logic [31:0] o_dm_req_data;
  logic [1:0]  o_dm_req_op;
  logic        i_dm_rsp_valid = 1'b0, o_dm_rsp_ready;
  logic [31:0] i_dm_rsp_data = 32'd0;
  logic [1:0]  i_dm_rsp_op = 2'd0;
  logic        o_timeout;

  dmi_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(11)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_m0_req_valid(i_m0_req_valid), .o_m0_req_ready(o_m0_req_ready),
    .i_m0_req_address(i_m0_req_address), .i_m0_req_data(i_m0_req_data), .i_m0_req_op(i_m0_req_op),
    .o_m0_rsp_valid(o_m0_rsp_valid), .i_m0_rsp_ready(i_m0_rsp_ready),
    .o_m0_rsp_data(o_m0_rsp_data), .o_m0_rsp_op(o_m0_rsp_op),
    .i_m1_req_valid(i_m1_req_valid), .o_m1_req_ready(o_m1_req_ready),
    .i_m1_req_address(i_m1_req_address), .i_m1_req_data(i_m1_req_data), .i_m1_req_op(i_m1_req_op),
    .o_m1_rsp_valid(o_m1_rsp_valid), .i_m1_rsp_ready(i_m1_rsp_ready),
    .o_m1_rsp_data(o_m1_rsp_data), .o_m1_rsp_op(o_m1_rsp_op),
    .o_dm_req_valid(o_dm_req_valid), .i_dm_req_ready(i_dm_req_ready),
    .o_dm_req_address(o_dm_req_address), .o_dm_req_data(o_dm_req_data), .o_dm_req_op(o_dm_req_op),
    .i_dm_rsp_valid(i_dm_rsp_valid), .o_dm_rsp_ready(o_dm_rsp_ready),
    .i_dm_rsp_data(i_dm_rsp_data), .i_dm_rsp_op(i_dm_rsp_op),
    .o_timeout(o_timeout)
  );

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;   // master favoured on a tie
  bit m_stale = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction. dm_lat < 0 means the DM never answers.
  task automatic txn(input bit v0, input bit v1,
                     input logic [6:0] a0, input logic [6:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] o0, input logic [1:0] o1,
                     input int req_stall, input int dm_lat,
                     input logic [31:0] rdata, input logic [1:0] rop,
                     input int mstall);
    int own;
    int pulses;
    bit got;
    logic [6:0]  ea;
    logic [31:0] ed, xd;
    logic [1:0]  eo, xo;
    own = (v0 && v1) ? m_ptr : (v0 ? 0 : 1);
    i_m0_req_valid = v0; i_m0_req_address = a0; i_m0_req_data = d0; i_m0_req_op = o0;
    i_m1_req_valid = v1; i_m1_req_address = a1; i_m1_req_data = d1; i_m1_req_op = o1;
    #1;
    chk("grant_m0", 32'(o_m0_req_ready), 32'(own == 0));
    chk("grant_m1", 32'(o_m1_req_ready), 32'(own == 1));
    ea = own ? a1 : a0;
    ed = own ? d1 : d0;
    eo = own ? o1 : o0;
    tick();
    if (own == 0) i_m0_req_valid = 1'b0; else i_m1_req_valid = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      chk("req_hold_valid", 32'(o_dm_req_valid), 32'd1);
      chk("req_hold_addr", 32'(o_dm_req_address), 32'(ea));
      chk("req_hold_data", o_dm_req_data, ed);
      chk("req_hold_op", 32'(o_dm_req_op), 32'(eo));
      chk("no_grant_req", 32'(o_m0_req_ready | o_m1_req_ready), 32'd0);
      tick();
    end
    chk("dm_req_valid", 32'(o_dm_req_valid), 32'd1);
    chk("dm_req_addr", 32'(o_dm_req_address), 32'(ea));
    chk("dm_req_data", o_dm_req_data, ed);
    chk("dm_req_op", 32'(o_dm_req_op), 32'(eo));
    i_dm_req_ready = 1'b1;
    tick();
    i_dm_req_ready = 1'b0;
    chk("wait_no_req", 32'(o_dm_req_valid), 32'd0);
    chk("wait_rsp_ready", 32'(o_dm_rsp_ready), 32'd1);
    if (m_stale && dm_lat >= 0) begin
      i_dm_rsp_valid = 1'b1; i_dm_rsp_data = 32'hBAD0_0000 ^ 32'($urandom_range(0, 65535));
      i_dm_rsp_op = 2'd0;
      tick();
      i_dm_rsp_valid = 1'b0;
      m_stale = 1'b0;
      chk("stale_dropped", 32'(o_m0_rsp_valid | o_m1_rsp_valid), 32'd0);
    end
    pulses = 0;
    if (dm_lat >= 0) begin
      for (int i = 0; i < dm_lat; i++) begin
        chk("no_early_rsp", 32'(o_m0_rsp_valid | o_m1_rsp_valid), 32'd0);
        tick();
      end
      i_dm_rsp_valid = 1'b1; i_dm_rsp_data = rdata; i_dm_rsp_op = rop;
      tick();
      i_dm_rsp_valid = 1'b0;
      xd = rdata; xo = rop;
    end else begin
      got = 1'b0;
      for (int i = 0; i < TO + 6 && !got; i++) begin
        tick();
        if (o_timeout) pulses++;
        got = own ? o_m1_rsp_valid : o_m0_rsp_valid;
      end
      chk("timeout_bound", 32'(got), 32'd1);
      xd = 32'd0; xo = 2'b10;
      m_stale = 1'b1;
    end
    for (int i = 0; i <= mstall; i++) begin
      chk("rsp_valid_own", 32'(own ? o_m1_rsp_valid : o_m0_rsp_valid), 32'd1);
      chk("rsp_valid_other", 32'(own ? o_m0_rsp_valid : o_m1_rsp_valid), 32'd0);
      chk("rsp_data", own ? o_m1_rsp_data : o_m0_rsp_data, xd);
      chk("rsp_op", 32'(own ? o_m1_rsp_op : o_m0_rsp_op), 32'(xo));
      chk("rsp_dm_ready", 32'(o_dm_rsp_ready), 32'd0);
      chk("no_grant_rsp", 32'(o_m0_req_ready | o_m1_req_ready), 32'd0);
      if ((i > 0 || dm_lat >= 0) && o_timeout) pulses++;
      if (i == mstall) begin
        if (own == 0) i_m0_rsp_ready = 1'b1; else i_m1_rsp_ready = 1'b1;
      end
      tick();
    end
    i_m0_rsp_ready = 1'b0; i_m1_rsp_ready = 1'b0;
    chk("timeout_pulses", 32'(pulses), 32'(dm_lat < 0));
    chk("rsp_done", 32'(o_m0_rsp_valid | o_m1_rsp_valid), 32'd0);
    m_ptr = 1 - own;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit rv0, rv1;
    int lat;
    i_reset = 1'b1;
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_m0_ready", 32'(o_m0_req_ready), 32'd0);
    chk("rst_m1_ready", 32'(o_m1_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(o_m0_rsp_valid | o_m1_rsp_valid), 32'd0);
    chk("rst_dm_req", 32'(o_dm_req_valid), 32'd0);
    chk("rst_dm_rsp_ready", 32'(o_dm_rsp_ready), 32'd1);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    chk("rst_addr", 32'(o_dm_req_address), 32'd0);

    // Contention from reset: m0, m1, m0, m1.
    for (int k = 0; k < 4; k++) begin
      chk("alt_expect", 32'(m_ptr), 32'(k % 2));
      txn(1'b1, 1'b1, 7'h20, 7'h30, 32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k),
          2'd1, 2'd2, 0, 1, 32'hA5A5_0000 + 32'(k), 2'd0, 0);
    end

    // Single read from m0.
    txn(1'b1, 1'b0, 7'h11, 7'h00, 32'd0, 32'd0, 2'd1, 2'd0, 0, 3, 32'hDEAD_BEEF, 2'd0, 0);

    // DM request backpressure, and a forwarded nop.
    txn(1'b0, 1'b1, 7'h00, 7'h44, 32'd0, 32'h1234_5678, 2'd0, 2'd2, 5, 2, 32'h0, 2'd0, 0);
    txn(1'b1, 1'b0, 7'h05, 7'h00, 32'hCAFE_0000, 32'd0, 2'd0, 2'd0, 1, 0, 32'h7, 2'd2, 1);

    // Watchdog, then a late response that must be dropped.
    txn(1'b1, 1'b0, 7'h16, 7'h00, 32'd0, 32'd0, 2'd1, 2'd0, 0, -1, 32'd0, 2'd0, 2);
    txn(1'b0, 1'b1, 7'h00, 7'h17, 32'd0, 32'd0, 2'd0, 2'd1, 0, 2, 32'h0BAD_F00D, 2'd0, 0);

    // Master backpressure: m0 owns so pointer favours m1; m1 stalls with m0 waiting.
    txn(1'b1, 1'b0, 7'h01, 7'h00, 32'd1, 32'd0, 2'd2, 2'd0, 0, 0, 32'd0, 2'd0, 0);
    txn(1'b1, 1'b1, 7'h02, 7'h03, 32'd2, 32'd3, 2'd1, 2'd1, 0, 1, 32'h5555_AAAA, 2'd0, 10);
    txn(1'b1, 1'b0, 7'h02, 7'h00, 32'd2, 32'd0, 2'd1, 2'd0, 0, 1, 32'h6666_0000, 2'd0, 0);

    // Randomized traffic.
    for (int k = 0; k < 30; k++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      txn(rv0, rv1, 7'($urandom), 7'($urandom), 32'($urandom), 32'($urandom),
          2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
          int'($urandom_range(0, 3)), lat, 32'($urandom), 2'($urandom_range(0, 1)) << 1,
          int'($urandom_range(0, 3)));
    end

    // Timeout from m0 leaves stale set and pointer at m1, then reset mid-WAIT.
    txn(1'b1, 1'b0, 7'h08, 7'h00, 32'd0, 32'd0, 2'd1, 2'd0, 0, -1, 32'd0, 2'd0, 0);
    i_m0_req_valid = 1'b1; i_m0_req_address = 7'h09; i_m0_req_op = 2'd1;
    tick();
    i_m0_req_valid = 1'b0;
    i_dm_req_ready = 1'b1;
    tick();
    i_dm_req_ready = 1'b0;
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    m_ptr = 0; m_stale = 1'b0;
    chk("rst_wait_rsp_valid", 32'(o_m0_rsp_valid | o_m1_rsp_valid), 32'd0);
    chk("rst_wait_dm_req", 32'(o_dm_req_valid), 32'd0);
    chk("rst_wait_timeout", 32'(o_timeout), 32'd0);
    i_dm_rsp_valid = 1'b1; i_dm_rsp_data = 32'hFFFF_0000; i_dm_rsp_op = 2'd0;
    #1;
    chk("stray_rsp_ready", 32'(o_dm_rsp_ready), 32'd1);
    tick();
    i_dm_rsp_valid = 1'b0;
    chk("stray_not_fwd", 32'(o_m0_rsp_valid | o_m1_rsp_valid), 32'd0);
    chk("stray_no_req", 32'(o_dm_req_valid), 32'd0);
    txn(1'b1, 1'b1, 7'h0A, 7'h0B, 32'hA, 32'hB, 2'd1, 2'd1, 0, 2, 32'h1357_9BDF, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
